// File: rtl/hazard_pkg.sv
// +--------------------------------------------------------------------+
// | hazard_pkg : shared FSM encodings, constants and load-use helper    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         STAT_W   = 16;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_FLUSH      = 2'b10,
    ST_MEM_WAIT   = 2'b11
  } hazard_state_e;

  // r0 is hard-wired zero, so a load "into" it never creates a dependency
  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] tar_reg,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return mem_read && (tar_reg != REG_ZERO) &&
           ((tar_reg == rs) || (uses_rt && (tar_reg == rt)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_sat_cnt.sv
// +--------------------------------------------------------------------+
// | hazard_sat_cnt : saturating event counter, async active-low reset  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +--------------------------------------------------------------------+
// | hazard_ctrl : pipeline hazard FSM (load-use stall, branch flush,   |
// |               data-memory wait). HAZARD_STAT_EN adds stall/flush   |
// |               statistics counters.                                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [4:0]        i_id_rs,
  input  logic [4:0]        i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_ex_mem_read,
  input  logic [4:0]        i_ex_tar_reg,
  input  logic              i_ex_branch_taken,
  input  logic              i_mem_busy,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_pipe_hold,
  output logic [1:0]        o_state
`ifdef HAZARD_STAT_EN
  ,
  output logic [STAT_W-1:0] o_stall_cyc,
  output logic [STAT_W-1:0] o_flush_cnt
`endif
);

  hazard_state_e r_state;
  hazard_state_e w_next_state;
  logic          w_load_use;

  assign w_load_use = load_use(i_ex_mem_read, i_ex_tar_reg, i_id_rs,
                               i_id_rt, i_id_uses_rt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_hold    = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (i_mem_busy) begin
          o_pc_write    = 1'b0;
          o_if_id_write = 1'b0;
          o_pipe_hold   = 1'b1;
          w_next_state  = ST_MEM_WAIT;
        end else if (i_ex_branch_taken) begin
          o_if_id_flush  = 1'b1;
          o_id_ex_bubble = 1'b1;
          w_next_state   = ST_FLUSH;
        end else if (w_load_use) begin
          o_pc_write     = 1'b0;
          o_if_id_write  = 1'b0;
          o_id_ex_bubble = 1'b1;
          w_next_state   = ST_LOAD_STALL;
        end
      end
      // one recovery cycle: hazards are not re-detected here
      ST_LOAD_STALL, ST_FLUSH: begin
        if (i_mem_busy) begin
          o_pc_write    = 1'b0;
          o_if_id_write = 1'b0;
          o_pipe_hold   = 1'b1;
          w_next_state  = ST_MEM_WAIT;
        end else begin
          w_next_state  = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_pipe_hold   = 1'b1;
        w_next_state  = i_mem_busy ? ST_MEM_WAIT : ST_RUN;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    if (!i_rst_n) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_bubble = 1'b1;
      o_pipe_hold    = 1'b0;
      w_next_state   = ST_RUN;
    end
  end

  assign o_state = r_state;

`ifdef HAZARD_STAT_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = !o_pc_write;
  assign w_flush_inc = (r_state == ST_RUN) && (w_next_state == ST_FLUSH);

  hazard_sat_cnt #(.WIDTH(STAT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_stall_inc),
    .o_count (o_stall_cyc)
  );

  hazard_sat_cnt #(.WIDTH(STAT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_flush_inc),
    .o_count (o_flush_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_hazard_ctrl : directed + randomized bench for hazard_ctrl       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       uses_rt = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_tar = '0;
  logic       br = 1'b0;
  logic       busy = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, bubble, hold;
  logic [1:0] state;
`ifdef HAZARD_STAT_EN
  logic [15:0] stall_cyc, flush_cnt;
`endif

  logic [6:0] obs;
  assign obs = {pc_write, if_id_write, if_id_flush, bubble, hold, state};

  int checks = 0;
  int errors = 0;

  // Reference model: "waiting" follows busy, a one-cycle recovery follows a
  // stall or flush started from normal running.
  bit m_wait, m_rec_load, m_rec_flush;
  int m_stall, m_flushc;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_uses_rt      (uses_rt),
    .i_ex_mem_read     (ex_mem_read),
    .i_ex_tar_reg      (ex_tar),
    .i_ex_branch_taken (br),
    .i_mem_busy        (busy),
    .o_pc_write        (pc_write),
    .o_if_id_write     (if_id_write),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_bubble    (bubble),
    .o_pipe_hold       (hold),
    .o_state           (state)
`ifdef HAZARD_STAT_EN
    ,
    .o_stall_cyc       (stall_cyc),
    .o_flush_cnt       (flush_cnt)
`endif
  );

  function automatic bit m_lu();
    return ex_mem_read && (ex_tar != 5'd0) &&
           ((ex_tar == id_rs) || (uses_rt && (ex_tar == id_rt)));
  endfunction

  function automatic logic [6:0] exp_out();
    logic [1:0] code;
    code = m_wait ? 2'd3 : m_rec_flush ? 2'd2 : m_rec_load ? 2'd1 : 2'd0;
    if (!rst_n)                     return 7'b0001000;
    if (m_wait || busy)             return {5'b00001, code};
    if (m_rec_load || m_rec_flush)  return {5'b11000, code};
    if (br)                         return {5'b11110, code};
    if (m_lu())                     return {5'b00010, code};
    return {5'b11000, code};
  endfunction

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic u, input logic mr, input logic [4:0] tar,
                       input logic b, input logic bz);
    @(negedge clk);
    rst_n = r; id_rs = rs; id_rt = rt; uses_rt = u;
    ex_mem_read = mr; ex_tar = tar; br = b; busy = bz;
    if (!r) begin
      m_wait = 0; m_rec_load = 0; m_rec_flush = 0; m_stall = 0; m_flushc = 0;
    end
    #1;
  endtask

  task automatic tick();
    logic [6:0] e;
    bit running, nf, nl;
    e = exp_out();
    running = !m_wait && !m_rec_load && !m_rec_flush;
    nf = running && !busy && br;
    nl = running && !busy && !br && m_lu();
    @(posedge clk);
    if (rst_n) begin
      if (!e[6] && m_stall < 65535) m_stall++;
      if (nf && m_flushc < 65535) m_flushc++;
      m_wait = busy; m_rec_flush = nf; m_rec_load = nl;
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 7'b0001000) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 7'b0001000); end
    tick();
    drive(0, 5, 5, 1, 1, 5, 1, 1);
    checks++;
    if (obs !== 7'b0001000) begin errors++; $display("FAIL reset_ignores_inputs: got %b expected %b", obs, 7'b0001000); end
    tick();
    drive(1, 1, 2, 0, 0, 3, 0, 0);
    checks++;
    if (obs !== 7'b1100000) begin errors++; $display("FAIL reset_release_normal: got %b expected %b", obs, 7'b1100000); end
    tick();
  endtask

  task automatic test_load_use();
    drive(1, 8, 0, 0, 1, 8, 0, 0);
    checks++;
    if (obs !== exp_out()) begin errors++; $display("FAIL load_use_detect: got %b expected %b", obs, exp_out()); end
    tick();
    drive(1, 8, 0, 0, 1, 8, 0, 0);
    checks++;
    if (obs !== 7'b1100001) begin errors++; $display("FAIL load_stall_state: got %b expected %b", obs, 7'b1100001); end
    tick();
    drive(1, 1, 2, 0, 0, 3, 0, 0);
    checks++;
    if (obs !== 7'b1100000) begin errors++; $display("FAIL load_stall_return: got %b expected %b", obs, 7'b1100000); end
    tick();
  endtask

  task automatic test_no_stall();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== 7'b1100000) begin errors++; $display("FAIL r0_no_stall: got %b expected %b", obs, 7'b1100000); end
    tick();
    drive(1, 3, 8, 0, 1, 8, 0, 0);
    checks++;
    if (obs !== 7'b1100000) begin errors++; $display("FAIL rt_unused_no_stall: got %b expected %b", obs, 7'b1100000); end
    tick();
    drive(1, 3, 8, 1, 1, 8, 0, 0);
    checks++;
    if (obs !== 7'b0001000) begin errors++; $display("FAIL rt_used_stall: got %b expected %b", obs, 7'b0001000); end
    tick();
    drive(1, 1, 2, 0, 0, 3, 0, 0);
    tick();
  endtask

  task automatic test_branch();
    drive(1, 8, 0, 0, 1, 8, 1, 0);
    checks++;
    if (obs !== 7'b1111000) begin errors++; $display("FAIL branch_over_load_use: got %b expected %b", obs, 7'b1111000); end
    tick();
    drive(1, 1, 2, 0, 0, 3, 0, 0);
    checks++;
    if (obs !== 7'b1100010) begin errors++; $display("FAIL flush_state: got %b expected %b", obs, 7'b1100010); end
`ifdef HAZARD_STAT_EN
    checks++;
    if (flush_cnt !== 16'(m_flushc)) begin errors++; $display("FAIL flush_count: got %0d expected %0d", flush_cnt, m_flushc); end
`endif
    tick();
  endtask

  task automatic test_mem_wait();
    int holds;
    holds = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, i < 3);
      checks++;
      if (obs !== exp_out()) begin errors++; $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, obs, exp_out()); end
      if (i < 4) begin
        checks++;
        if (if_id_flush !== 1'b0) begin errors++; $display("FAIL flush_during_wait: got %b expected 0", if_id_flush); end
      end
      holds += int'(hold);
      tick();
      if (i == 3) begin
        checks++;
        if (holds != 4) begin errors++; $display("FAIL hold_cycles: got %0d expected 4", holds); end
      end
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 7'b1100010) begin errors++; $display("FAIL branch_after_release: got %b expected %b", obs, 7'b1100010); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== 7'b0000111) begin errors++; $display("FAIL wait_entered: got %b expected %b", obs, 7'b0000111); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== 7'b0001000) begin errors++; $display("FAIL async_reset_in_wait: got %b expected %b", obs, 7'b0001000); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 7'b1100000) begin errors++; $display("FAIL post_reset_normal: got %b expected %b", obs, 7'b1100000); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 60) != 0, 5'($urandom % 4), 5'($urandom % 4),
            1'($urandom % 2), ($urandom % 2) == 0, 5'($urandom % 4),
            ($urandom % 6) == 0, ($urandom % 4) == 0);
      checks++;
      if (obs !== exp_out()) begin errors++; $display("FAIL random_%0d: got %b expected %b", i, obs, exp_out()); end
      checks++;
      if (if_id_flush && hold) begin errors++; $display("FAIL flush_hold_excl_%0d: got flush=1 hold=1 expected not both", i); end
`ifdef HAZARD_STAT_EN
      checks++;
      if (stall_cyc !== 16'(m_stall) || flush_cnt !== 16'(m_flushc)) begin
        errors++;
        $display("FAIL random_counters_%0d: got %0d/%0d expected %0d/%0d", i, stall_cyc, flush_cnt, m_stall, m_flushc);
      end
`endif
      tick();
    end
  endtask

`ifdef HAZARD_STAT_EN
  task automatic test_saturation();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 70000; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (stall_cyc !== 16'hFFFF || m_stall != 65535) begin
      errors++; $display("FAIL stall_saturate: got %h expected ffff", stall_cyc);
    end
    tick();
  endtask
`endif

  initial begin
    m_wait = 0; m_rec_load = 0; m_rec_flush = 0; m_stall = 0; m_flushc = 0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait();
    test_reset_mid_wait();
    test_random();
`ifdef HAZARD_STAT_EN
    test_saturation();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
